// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one sync FIFO write port
// among NUM_REQ valid/ready producers. A grant lasts up to MAX_BURST beats;
// the winner's data reaches the FIFO combinationally, gated by full_i.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic                      full_i,
  output logic                      wr_en_o,
  output logic [DATA_W-1:0]         data_o,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic                      busy_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  logic [0:0]       state;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] next_idx;
  logic [CNT_W-1:0] beat_cnt;
  logic             any_valid;
  logic             in_burst;
  logic             g_valid;
  logic             beat;
  logic             last_beat;

  assign in_burst  = (state == S_BURST);
  assign g_valid   = req_valid_i[grant_idx];
  // rst gates the beat so a mid-burst reset never writes in the reset cycle
  assign beat      = in_burst && g_valid && !full_i && !rst;
  assign last_beat = (beat_cnt == CNT_W'(MAX_BURST - 1));

  // Round-robin pick: first valid index after last_grant, wrapping to 0
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand      = '0;
    next_idx  = last_grant;
    any_valid = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((32'(last_grant) + i) % NUM_REQ);
      if (!any_valid && req_valid_i[cand]) begin
        next_idx  = cand;
        any_valid = 1'b1;
      end
    end
  end

  // FIFO write port and per-requester handshake driven from the current grant
  always_comb begin
    req_ready_o = '0;
    grant_o     = '0;
    wr_en_o     = beat;
    data_o      = '0;
    busy_o      = in_burst;
    if (in_burst) begin
      grant_o[grant_idx] = 1'b1;
      if (!full_i && !rst) begin
        req_ready_o[grant_idx] = 1'b1;
      end
    end
    if (beat) begin
      data_o = req_data_i[grant_idx*DATA_W +: DATA_W];
    end
  end

  // Grant FSM: one arbitration cycle in IDLE, then hold grant until burst limit or release
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      grant_idx  <= '0;
      beat_cnt   <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
    end else begin
      case (state)
        S_IDLE: begin
          if (any_valid) begin
            grant_idx <= next_idx;
            beat_cnt  <= '0;
            state     <= S_BURST;
          end
        end
        S_BURST: begin
          if (!g_valid) begin
            state      <= S_IDLE;
            last_grant <= grant_idx;
            beat_cnt   <= '0;
          end else if (beat) begin
            if (last_beat) begin
              state      <= S_IDLE;
              last_grant <= grant_idx;
              beat_cnt   <= '0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
